// File: rtl/fsm_lane_ser_pkg.sv
// fsm_pkg: state encoding and beat-count helper shared by the lane serializer
package fsm_pkg;
  typedef enum logic [1:0] {IDLE, WORK, DONE} state_t;
  function automatic int beats(input int in_w, input int out_w);
    return in_w / out_w;
  endfunction
endpackage

// File: rtl/fsm_lane_ser.sv
// fsm_lane_ser: word-in (in_valid/in_ready/fsm_in_q) to OUT_W-bit beats out (fsm_out/out_valid/out_ready/beat_idx) with busy and done pulse
module fsm_lane_ser
  import fsm_pkg::*;
#(
  parameter int IN_W = 8,
  parameter int OUT_W = 4,
  parameter int LSB_FIRST = 0,
  localparam int BEATS = beats(IN_W, OUT_W),
  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  fsm_in_q,
  output logic [OUT_W-1:0] fsm_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    beat_idx,
  output logic             busy,
  output logic             done
);
  if (OUT_W < 1 || IN_W % OUT_W != 0 || (LSB_FIRST != 0 && LSB_FIRST != 1)) begin : g_bad_params
    $error("fsm_lane_ser: illegal IN_W/OUT_W/LSB_FIRST");
  end
  state_t state;
  logic [IN_W-1:0] word_q;
  logic [IN_W-1:0] sh;
  logic [CW-1:0] beat_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      word_q <= '0;
      beat_q <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          state <= WORK;
          word_q <= fsm_in_q;
          beat_q <= '0;
        end
        WORK: if (out_ready) begin
          if (beat_q == CW'(BEATS - 1)) begin
            state <= DONE;
            beat_q <= '0;
          end else beat_q <= beat_q + CW'(1);
        end
        DONE: begin
          state <= IDLE;
          word_q <= '0;
        end
        default: begin
          state <= IDLE;
          word_q <= '0;
          beat_q <= '0;
        end
      endcase
    end
  end
  always_comb begin
    sh = word_q >> ((LSB_FIRST != 0) ? int'(beat_q) * OUT_W : IN_W - OUT_W - int'(beat_q) * OUT_W);
    in_ready = state == IDLE;
    out_valid = state == WORK;
    fsm_out = (state == WORK) ? sh[OUT_W-1:0] : '0;
    beat_idx = (state == WORK) ? beat_q : '0;
    busy = state != IDLE;
    done = state == DONE;
  end
endmodule

// File: tb/tb_fsm_lane_ser.sv
// tb_fsm_lane_ser: three serializer configurations checked against an arithmetic beat model
module tb_fsm_lane_ser;
  logic clk = 0, rst = 1, iv = 0, ordy = 0;
  logic [15:0] d = '0;
  int sel = 0;
  int n_cmp = 0, n_err = 0;
  int cin[3] = '{8, 16, 8};
  int cout[3] = '{4, 4, 8};
  int clsb[3] = '{0, 1, 0};
  logic [2:0] ir, ov, bz, dn;
  logic [3:0] fa, fb;
  logic [7:0] fc, o_f;
  logic ba, bc;
  logic [1:0] bb, o_b;
  always #5 clk = ~clk;
  fsm_lane_ser u_a (
    .clk(clk), .rst(rst), .in_valid(iv && sel == 0), .in_ready(ir[0]), .fsm_in_q(d[7:0]),
    .fsm_out(fa), .out_valid(ov[0]), .out_ready(ordy), .beat_idx(ba), .busy(bz[0]), .done(dn[0])
  );
  fsm_lane_ser #(.IN_W(16), .OUT_W(4), .LSB_FIRST(1)) u_b (
    .clk(clk), .rst(rst), .in_valid(iv && sel == 1), .in_ready(ir[1]), .fsm_in_q(d),
    .fsm_out(fb), .out_valid(ov[1]), .out_ready(ordy), .beat_idx(bb), .busy(bz[1]), .done(dn[1])
  );
  fsm_lane_ser #(.OUT_W(8)) u_c (
    .clk(clk), .rst(rst), .in_valid(iv && sel == 2), .in_ready(ir[2]), .fsm_in_q(d[7:0]),
    .fsm_out(fc), .out_valid(ov[2]), .out_ready(ordy), .beat_idx(bc), .busy(bz[2]), .done(dn[2])
  );
  always_comb begin
    o_f = (sel == 0) ? 8'(fa) : (sel == 1) ? 8'(fb) : fc;
    o_b = (sel == 0) ? 2'(ba) : (sel == 1) ? bb : 2'(bc);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, sel, obs, exp);
    end
  endtask
  task automatic outs(input string tag, input int r, input int v, input int f, input int b, input int bs, input int dne);
    chk({tag, ".in_ready"}, int'(ir[sel]), r);
    chk({tag, ".out_valid"}, int'(ov[sel]), v);
    chk({tag, ".fsm_out"}, int'(o_f), f);
    chk({tag, ".beat_idx"}, int'(o_b), b);
    chk({tag, ".busy"}, int'(bz[sel]), bs);
    chk({tag, ".done"}, int'(dn[sel]), dne);
  endtask
  function automatic int chunk(input int s, input logic [15:0] w, input int j);
    int sh;
    sh = clsb[s] != 0 ? j * cout[s] : cin[s] - cout[s] * (j + 1);
    return int'((w >> sh) & ((16'd1 << cout[s]) - 16'd1));
  endfunction
  task automatic xact(input int s, input logic [15:0] w, input int st0, input int rmax, input bit keep);
    int nb, st;
    nb = cin[s] / cout[s];
    sel = s;
    chk("accept.in_ready", int'(ir[s]), 1);
    iv = 1;
    d = w;
    ordy = 1'($urandom_range(0, 1));
    tick();
    if (keep) d = 16'hFF;
    else iv = 0;
    for (int j = 0; j < nb; j++) begin
      st = (j == 0 ? st0 : 0) + int'($urandom_range(0, rmax));
      for (int k = 0; k <= st; k++) begin
        ordy = (k == st);
        outs($sformatf("beat%0d", j), 0, 1, chunk(s, w, j), j, 1, 0);
        tick();
      end
    end
    ordy = 1'($urandom_range(0, 1));
    outs("done", 0, 0, 0, 0, 1, 1);
    tick();
    outs("idle", 1, 0, 0, 0, 0, 0);
  endtask
  initial begin
    rst = 1;
    tick();
    tick();
    for (int s = 0; s < 3; s++) begin
      sel = s;
      outs("reset", 1, 0, 0, 0, 0, 0);
    end
    rst = 0;
    xact(0, 16'hA5, 0, 0, 0);
    xact(1, 16'h1234, 0, 0, 0);
    xact(0, 16'h3C, 5, 0, 0);
    xact(0, 16'h12, 0, 0, 1);
    xact(0, 16'hFF, 0, 0, 0);
    xact(2, 16'h81, 0, 0, 0);
    sel = 0;
    iv = 1;
    d = 16'h5A;
    tick();
    iv = 0;
    ordy = 0;
    outs("mid.w1", 0, 1, 5, 0, 1, 0);
    tick();
    rst = 1;
    outs("mid.w2", 0, 1, 5, 0, 1, 0);
    tick();
    rst = 0;
    outs("mid.rst", 1, 0, 0, 0, 0, 0);
    tick();
    outs("mid.after", 1, 0, 0, 0, 0, 0);
    xact(0, 16'h96, 0, 1, 0);
    rst = 1;
    iv = 1;
    d = 16'hFF;
    tick();
    rst = 0;
    iv = 0;
    outs("rst_iv", 1, 0, 0, 0, 0, 0);
    tick();
    outs("rst_iv.next", 1, 0, 0, 0, 0, 0);
    for (int n = 0; n < 30; n++) begin
      int s;
      s = int'($urandom_range(0, 2));
      xact(s, 16'($urandom) & 16'((32'd1 << cin[s]) - 1), 0, 3, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fsm_lane_ser.md
# fsm_lane_ser

Parametrised successor to the three-state IDLE/WORK/DONE sequencer. Accepts one IN_W-bit word per transaction through a valid/ready handshake. Emits the word as IN_W/OUT_W output beats of OUT_W bits each, with output backpressure, a done pulse and a beat index. Sits between a word-wide producer and a narrow lane consumer. With the default parameters, the first beat equals the legacy WORK-state output of in[7:4].

## Interface
Parameters:
- IN_W, 8: input word width; must be a multiple of OUT_W.
- OUT_W, 4: output lane count (bits per beat); 1 ≤ OUT_W ≤ IN_W.
- LSB_FIRST, 0: 0 emits the most-significant chunk first; 1 emits the least-significant chunk first.
- BEATS: derived, IN_W/OUT_W. CW: derived, max(1, $clog2(BEATS)).

Ports:
- clk, input, 1: single clock; all logic is on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: the producer offers fsm_in_q.
- in_ready, output, 1: the block can accept a word.
- fsm_in_q, input, IN_W: input word.
- fsm_out, output, OUT_W: current beat data; all zeros whenever out_valid=0.
- out_valid, output, 1: fsm_out holds a valid beat.
- out_ready, input, 1: the consumer accepts the beat.
- beat_idx, output, CW: index of the current beat (0..BEATS-1); 0 outside WORK.
- busy, output, 1: state is not IDLE.
- done, output, 1: one-cycle pulse in DONE.

## Operation
- States: IDLE, WORK, DONE. A two-bit state_t; the unused encoding recovers to IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid, capture fsm_in_q into word_q, clear beat_q and go to WORK.
  - Without in_valid, stay in IDLE.
- WORK:
  - out_valid=1, in_ready=0.
  - Beat selection, with k=beat_q:
    - LSB_FIRST=0: fsm_out = word_q[IN_W-1-k*OUT_W -: OUT_W].
    - LSB_FIRST=1: fsm_out = word_q[k*OUT_W +: OUT_W].
  - On out_ready: if k==BEATS-1, go to DONE; otherwise increment beat_q.
  - Without out_ready: hold state; fsm_out and beat_idx stay stable.
- DONE:
  - done=1, in_ready=0, out_valid=0.
  - Go to IDLE unconditionally next cycle; clear word_q.
- Outputs are combinational from state, word_q and beat_q. There is no combinational path from in_valid or out_ready to any output.
- BEATS=1: WORK lasts until the first out_ready, then DONE.
- Reset values: state=IDLE, word_q=0, beat_q=0. Outputs at reset: in_ready=1, out_valid=0, fsm_out=0, beat_idx=0, busy=0, done=0.

## Timing
- Accept happens at edge N (in_valid && in_ready). out_valid rises in cycle N+1 with beat 0.
- Each beat completes at an edge where out_valid && out_ready.
- The last beat is accepted at edge M. Cycle M+1 is DONE (done=1). Cycle M+2 is IDLE with in_ready=1.
- Minimum period: BEATS+2 cycles per word with out_ready tied high (4 cycles at the defaults).
- in_valid during WORK or DONE is ignored; the producer must hold it until in_ready.
- rst asserted mid-transaction (any state) takes effect at the next edge. The partial word is discarded, there is no done pulse, and all outputs take their reset values in the following cycle.
- rst and in_valid in the same cycle: rst wins; nothing is captured.
- Stall of any length in WORK: no data loss; busy stays 1.

## Structure
- Package fsm_pkg holds:
  - typedef enum logic [1:0] {IDLE, WORK, DONE} state_t.
  - A function beats(in_w, out_w).
- Elaboration-time checks, erroring if violated: IN_W % OUT_W == 0, OUT_W ≥ 1, and LSB_FIRST ∈ {0,1}.
- No sub-module. State register, next-state logic, datapath registers and output decode are all in one module.

## Test plan
- Defaults, out_ready=1: send 8'hA5. Expected fsm_out: 4'hA (beat_idx 0), then 4'h5 (beat_idx 1), then done=1, then in_ready=1. 4 cycles total.
- LSB_FIRST=1, IN_W=16, OUT_W=4: send 16'h1234. Expected beats 4, 3, 2, 1 with beat_idx 0..3, then a single done pulse.
- Backpressure, defaults: send 8'h3C, hold out_ready=0 for 5 cycles, then release.
  - fsm_out=4'h3 stays stable with out_valid=1 throughout the stall.
  - Then 4'hC, then done.
- in_valid held high with data 8'hFF while a transaction for 8'h12 is in progress. The second word is accepted only in the IDLE cycle after done, and its beats are 4'hF, 4'hF.
- Reset mid-stream: assert rst in cycle 2 of WORK. Next cycle: out_valid=0, fsm_out=0, busy=0, and done never pulses. A new word is then processed normally.
- OUT_W=8 (BEATS=1): send 8'h81. Expected: one beat of 8'h81 with beat_idx 0, then done, then IDLE. 3-cycle period.
